// File: rtl/jpeg_block_sequencer.sv
// Control FSM that sequences one 8x8 block through load, DCT, quantize, zigzag and Huffman.
// Every output except blk_ready is registered, so each strobe lines up with the state it belongs to.
module jpeg_block_sequencer #(
    parameter int DCT_CYCLES   = 16,
    parameter int QUANT_LAT    = 2,
    parameter int HUFF_TIMEOUT = 1024,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic             blk_is_luma,
    input  logic             huff_done,
    output logic             input_enable,
    output logic             dct_enable,
    output logic             dct_end_enable,
    output logic [7:0]       matrix_row,
    output logic             zigzag_input_enable,
    output logic             zigag_enable,
    output logic             Huffman_start,
    output logic             is_luminance,
    output logic             busy,
    output logic             block_done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] block_count,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_DCT    = 4'd2,
        S_DLATCH = 4'd3,
        S_QUANT  = 4'd4,
        S_ZZ     = 4'd5,
        S_HSTART = 4'd6,
        S_HWAIT  = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    localparam logic [31:0] DCT_LAST  = 32'(DCT_CYCLES - 1);
    localparam logic [31:0] QUANT_END = 32'(QUANT_LAT);
    localparam logic [31:0] HUFF_LAST = 32'(HUFF_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [2:0]       row_q, row_d;
    logic             is_luminance_q, is_luminance_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] block_count_q, block_count_d;
    logic             input_enable_q, input_enable_d;
    logic             dct_enable_q, dct_enable_d;
    logic             dct_end_enable_q, dct_end_enable_d;
    logic             zigzag_input_enable_q, zigzag_input_enable_d;
    logic             zigag_enable_q, zigag_enable_d;
    logic             huffman_start_q, huffman_start_d;
    logic             busy_q, busy_d;
    logic             block_done_q, block_done_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        row_d          = row_q;
        is_luminance_d = is_luminance_q;
        timeout_err_d  = timeout_err_q;
        block_count_d  = block_count_q;

        case (state_q)
            S_IDLE: begin
                if (blk_valid) begin
                    state_d        = S_LOAD;
                    is_luminance_d = blk_is_luma;
                    timeout_err_d  = 1'b0;
                end
            end
            S_LOAD: begin
                state_d = S_DCT;
                cnt_d   = '0;
            end
            S_DCT: begin
                if (cnt_q == DCT_LAST) begin
                    state_d = S_DLATCH;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DLATCH: begin
                state_d = S_QUANT;
                cnt_d   = '0;
                row_d   = '0;
            end
            S_QUANT: begin
                // Each row is held until the quantizer output for it has settled.
                if (cnt_q == QUANT_END) begin
                    cnt_d = '0;
                    if (row_q == 3'd7) begin
                        state_d = S_ZZ;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_ZZ: state_d = S_HSTART;
            S_HSTART: begin
                state_d = S_HWAIT;
                cnt_d   = '0;
            end
            S_HWAIT: begin
                // Completion takes priority over a timeout landing in the same cycle.
                if (huff_done) begin
                    state_d       = S_DONE;
                    block_count_d = block_count_q + CNT_W'(1);
                end else if (cnt_q == HUFF_LAST) begin
                    state_d       = S_DONE;
                    timeout_err_d = 1'b1;
                    block_count_d = block_count_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        input_enable_d        = (state_d == S_LOAD);
        dct_enable_d          = (state_d == S_DCT);
        dct_end_enable_d      = (state_d == S_DLATCH);
        zigzag_input_enable_d = (state_d == S_QUANT) && (cnt_d == QUANT_END);
        zigag_enable_d        = (state_d == S_ZZ);
        huffman_start_d       = (state_d == S_HSTART);
        busy_d                = (state_d != S_IDLE);
        block_done_d          = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q               <= S_IDLE;
            cnt_q                 <= '0;
            row_q                 <= '0;
            is_luminance_q        <= 1'b0;
            timeout_err_q         <= 1'b0;
            block_count_q         <= '0;
            input_enable_q        <= 1'b0;
            dct_enable_q          <= 1'b0;
            dct_end_enable_q      <= 1'b0;
            zigzag_input_enable_q <= 1'b0;
            zigag_enable_q        <= 1'b0;
            huffman_start_q       <= 1'b0;
            busy_q                <= 1'b0;
            block_done_q          <= 1'b0;
        end else begin
            state_q               <= state_d;
            cnt_q                 <= cnt_d;
            row_q                 <= row_d;
            is_luminance_q        <= is_luminance_d;
            timeout_err_q         <= timeout_err_d;
            block_count_q         <= block_count_d;
            input_enable_q        <= input_enable_d;
            dct_enable_q          <= dct_enable_d;
            dct_end_enable_q      <= dct_end_enable_d;
            zigzag_input_enable_q <= zigzag_input_enable_d;
            zigag_enable_q        <= zigag_enable_d;
            huffman_start_q       <= huffman_start_d;
            busy_q                <= busy_d;
            block_done_q          <= block_done_d;
        end
    end

    assign blk_ready           = (state_q == S_IDLE);
    assign input_enable        = input_enable_q;
    assign dct_enable          = dct_enable_q;
    assign dct_end_enable      = dct_end_enable_q;
    assign matrix_row          = {5'd0, row_q};
    assign zigzag_input_enable = zigzag_input_enable_q;
    assign zigag_enable        = zigag_enable_q;
    assign Huffman_start       = huffman_start_q;
    assign is_luminance        = is_luminance_q;
    assign busy                = busy_q;
    assign block_done          = block_done_q;
    assign timeout_err         = timeout_err_q;
    assign block_count         = block_count_q;
    assign state               = state_q;

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Directed bench: default-parameter sequencer, a short-timeout instance and a 1-cycle-timeout/2-bit-count instance.
module tb_jpeg_block_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instance A: defaults
    logic a_valid = 0, a_luma = 0, a_done = 0;
    logic a_ready, a_ie, a_de, a_dee, a_zie, a_zz, a_hs, a_lum, a_busy, a_bd, a_terr;
    logic [7:0] a_row;
    logic [15:0] a_cnt;
    logic [3:0] a_state;
    logic [7:0] a_strb;
    assign a_strb = {a_ie, a_de, a_dee, a_zie, a_zz, a_hs, a_bd, a_busy};

    jpeg_block_sequencer u_dut_a (
        .clock(clock), .reset(reset), .blk_valid(a_valid), .blk_ready(a_ready),
        .blk_is_luma(a_luma), .huff_done(a_done), .input_enable(a_ie), .dct_enable(a_de),
        .dct_end_enable(a_dee), .matrix_row(a_row), .zigzag_input_enable(a_zie),
        .zigag_enable(a_zz), .Huffman_start(a_hs), .is_luminance(a_lum), .busy(a_busy),
        .block_done(a_bd), .timeout_err(a_terr), .block_count(a_cnt), .state(a_state)
    );

    // Instance B: short Huffman timeout
    logic b_valid = 0, b_luma = 0, b_done = 0;
    logic b_ready, b_ie, b_de, b_dee, b_zie, b_zz, b_hs, b_lum, b_busy, b_bd, b_terr;
    logic [7:0] b_row;
    logic [15:0] b_cnt;
    logic [3:0] b_state;

    jpeg_block_sequencer #(.HUFF_TIMEOUT(8)) u_dut_b (
        .clock(clock), .reset(reset), .blk_valid(b_valid), .blk_ready(b_ready),
        .blk_is_luma(b_luma), .huff_done(b_done), .input_enable(b_ie), .dct_enable(b_de),
        .dct_end_enable(b_dee), .matrix_row(b_row), .zigzag_input_enable(b_zie),
        .zigag_enable(b_zz), .Huffman_start(b_hs), .is_luminance(b_lum), .busy(b_busy),
        .block_done(b_bd), .timeout_err(b_terr), .block_count(b_cnt), .state(b_state)
    );

    // Instance C: 1-cycle timeout, 2-bit block counter
    logic c_valid = 0, c_luma = 0, c_done = 0;
    logic c_ready, c_ie, c_de, c_dee, c_zie, c_zz, c_hs, c_lum, c_busy, c_bd, c_terr;
    logic [7:0] c_row;
    logic [1:0] c_cnt;
    logic [3:0] c_state;

    jpeg_block_sequencer #(.HUFF_TIMEOUT(1), .CNT_W(2)) u_dut_c (
        .clock(clock), .reset(reset), .blk_valid(c_valid), .blk_ready(c_ready),
        .blk_is_luma(c_luma), .huff_done(c_done), .input_enable(c_ie), .dct_enable(c_de),
        .dct_end_enable(c_dee), .matrix_row(c_row), .zigzag_input_enable(c_zie),
        .zigag_enable(c_zz), .Huffman_start(c_hs), .is_luminance(c_lum), .busy(c_busy),
        .block_done(c_bd), .timeout_err(c_terr), .block_count(c_cnt), .state(c_state)
    );

    // Expected nominal-block waveforms, cycle k after the accept edge.
    function automatic logic [7:0] exp_strb(input int k);
        logic ie, de, dee, zie, zz, hs, bd, bz;
        ie  = (k == 1);
        de  = (k >= 2 && k <= 17);
        dee = (k == 18);
        zie = (k >= 21 && k <= 42 && ((k - 21) % 3 == 0));
        zz  = (k == 43);
        hs  = (k == 44);
        bd  = (k == 51);
        bz  = (k >= 1 && k <= 51);
        return {ie, de, dee, zie, zz, hs, bd, bz};
    endfunction

    function automatic int exp_state(input int k);
        if (k == 1) return 1;
        if (k <= 17) return 2;
        if (k == 18) return 3;
        if (k <= 42) return 4;
        if (k == 43) return 5;
        if (k == 44) return 6;
        if (k <= 50) return 7;
        if (k == 51) return 8;
        return 0;
    endfunction

    function automatic int exp_row(input int k);
        if (k >= 19 && k <= 42) return (k - 19) / 3;
        return 0;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int hw;
        int lat;
        int exp_c[5];
        exp_c = '{1, 2, 3, 0, 1};

        // Reset then idle
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            chk($sformatf("idle%0d strobes", i), 32'(a_strb), 32'd0);
            chk($sformatf("idle%0d row", i), 32'(a_row), 32'd0);
            chk($sformatf("idle%0d state", i), 32'(a_state), 32'd0);
            chk($sformatf("idle%0d ready", i), 32'(a_ready), 32'd1);
            chk($sformatf("idle%0d misc", i), 32'({a_lum, a_terr, a_cnt}), 32'd0);
        end
        chk("idle b state", 32'({b_state, b_cnt}), 32'd0);
        chk("idle c state", 32'({c_state, c_cnt, c_ready}), 32'd1);

        // Nominal luma block, huff_done pulsed in cycle 50
        a_valid = 1'b1; a_luma = 1'b1;
        @(posedge clock); #1;
        a_valid = 1'b0; a_luma = 1'b0;
        for (int k = 1; k <= 52; k++) begin
            if (k > 1) begin @(posedge clock); #1; end
            chk($sformatf("nom k=%0d strobes", k), 32'(a_strb), 32'(exp_strb(k)));
            chk($sformatf("nom k=%0d row", k), 32'(a_row), 32'(exp_row(k)));
            chk($sformatf("nom k=%0d state", k), 32'(a_state), 32'(exp_state(k)));
            chk($sformatf("nom k=%0d luma", k), 32'(a_lum), 32'd1);
            chk($sformatf("nom k=%0d ready", k), 32'(a_ready), (k == 52) ? 32'd1 : 32'd0);
            a_done = (k == 50);
        end
        chk("nom block_count", 32'(a_cnt), 32'd1);
        chk("nom timeout_err", 32'(a_terr), 32'd0);

        // Busy rejection with huff_done held high (also covers done during HSTART)
        a_done = 1'b1; a_valid = 1'b1; a_luma = 1'b0;
        @(posedge clock);
        for (int k = 1; k <= 48; k++) begin
            #1;
            if (k <= 46) begin
                chk($sformatf("busy k=%0d ready", k), 32'(a_ready), 32'd0);
                chk($sformatf("busy k=%0d luma", k), 32'(a_lum), 32'd0);
            end
            if (k == 44) chk("early hstart state", 32'(a_state), 32'd6);
            if (k == 45) chk("early hwait state", 32'({a_state, a_bd}), 32'({4'd7, 1'b0}));
            if (k == 46) chk("early done state", 32'({a_state, a_bd}), 32'({4'd8, 1'b1}));
            if (k == 47) chk("busy reaccept idle", 32'({a_state, a_ready, a_cnt}), 32'({4'd0, 1'b1, 16'd2}));
            if (k == 48) chk("busy second accept", 32'({a_state, a_lum, a_ready}), 32'({4'd1, 1'b1, 1'b0}));
            a_luma = k[0];
            if (k < 48) @(posedge clock);
        end
        a_valid = 1'b0;
        t = 0;
        while (a_state != 4'd0 && t < 100) begin @(posedge clock); #1; t++; end
        chk("busy second block count", 32'({a_state, a_cnt}), 32'({4'd0, 16'd3}));
        a_done = 1'b0;

        // Huffman timeout on B
        b_valid = 1'b1; b_done = 1'b0;
        @(posedge clock); #1;
        b_valid = 1'b0;
        t = 0;
        while (b_state != 4'd7 && t < 100) begin @(posedge clock); #1; t++; end
        chk("to reach hwait", 32'(t), 32'd44);
        hw = 0;
        while (b_state == 4'd7 && hw < 50) begin @(posedge clock); #1; hw++; end
        chk("to hwait length", 32'(hw), 32'd8);
        chk("to done", 32'({b_state, b_bd, b_terr}), 32'({4'd8, 1'b1, 1'b1}));
        @(posedge clock); #1;
        chk("to after done", 32'({b_state, b_bd, b_terr, b_cnt}), 32'({4'd0, 1'b0, 1'b1, 16'd1}));
        b_valid = 1'b1; b_done = 1'b1;
        @(posedge clock); #1;
        b_valid = 1'b0;
        chk("to cleared on accept", 32'({b_state, b_terr}), 32'({4'd1, 1'b0}));
        t = 0;
        while (b_state != 4'd0 && t < 100) begin @(posedge clock); #1; t++; end
        chk("to second block", 32'({b_state, b_terr, b_cnt}), 32'({4'd0, 1'b0, 16'd2}));

        // HUFF_TIMEOUT=1 with done high, and 2-bit count wrap on C
        c_done = 1'b1;
        for (int b = 0; b < 5; b++) begin
            c_valid = 1'b1;
            @(posedge clock); #1;
            c_valid = 1'b0;
            lat = 1;
            while (!c_bd && lat < 100) begin @(posedge clock); #1; lat++; end
            chk($sformatf("wrap b%0d latency", b), 32'(lat), 32'd46);
            chk($sformatf("wrap b%0d timeout_err", b), 32'(c_terr), 32'd0);
            @(posedge clock); #1;
            chk($sformatf("wrap b%0d count", b), 32'(c_cnt), 32'(exp_c[b]));
        end
        c_done = 1'b0;

        // Reset mid-QUANT on A
        a_valid = 1'b1; a_luma = 1'b1;
        @(posedge clock); #1;
        a_valid = 1'b0;
        t = 0;
        while (a_row != 8'd4 && t < 100) begin @(posedge clock); #1; t++; end
        chk("midrst reach row4", 32'(t), 32'd30);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midrst strobes", 32'(a_strb), 32'd0);
        chk("midrst state row", 32'({a_state, a_row}), 32'd0);
        chk("midrst misc", 32'({a_lum, a_terr, a_cnt}), 32'd0);
        chk("midrst ready", 32'(a_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk($sformatf("midrst quiet%0d", i), 32'({a_bd, a_state}), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jpeg_block_sequencer.md
Name: jpeg_block_sequencer

Overview:
Top-level control FSM for the single-block JPEG encode datapath. It accepts one 8x8 block per valid/ready handshake and sequences the pipeline in order: input buffer load, DCT, DCT result latch, row-by-row quantize into the zigzag buffer, zigzag scan, then Huffman start. It waits for Huffman completion or timeout, then reports the block done and returns idle. It drives every enable/strobe input of the encoder top, replacing testbench-driven sequencing.

Parameters:
DCT_CYCLES, 16, cycles dct_enable is held high (legal range 1..255)
QUANT_LAT, 2, cycles from a matrix_row change to valid quantize output (0..15)
HUFF_TIMEOUT, 1024, maximum cycles spent in HWAIT before abort (>=1)
CNT_W, 16, width of block_count

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
blk_valid  in  1  upstream has a block on pix_data
blk_ready  out  1  sequencer can accept a block
blk_is_luma  in  1  component type of offered block, sampled on accept
huff_done  in  1  Huffman controller finished the block (level or pulse)
input_enable  out  1  load strobe to the input buffer
dct_enable  out  1  DCT run enable
dct_end_enable  out  1  latch strobe to the DCT result buffer
matrix_row  out  8  quantize/zigzag row index, 0..7
zigzag_input_enable  out  1  write current quantized row into the zigzag buffer
zigag_enable  out  1  zigzag scan strobe
Huffman_start  out  1  Huffman controller start pulse
is_luminance  out  1  latched blk_is_luma, held for the whole block
busy  out  1  high in every state except IDLE
block_done  out  1  one-cycle completion pulse
timeout_err  out  1  sticky: last block aborted on Huffman timeout
block_count  out  CNT_W  blocks completed, wraps to 0
state  out  4  current FSM state encoding (debug)

Behaviour:
- Reset: state=IDLE; all strobes, matrix_row, is_luminance, busy, timeout_err and block_count are 0. Reset mid-block aborts immediately with no block_done.
- All outputs except blk_ready are registered. blk_ready = (state==IDLE) combinationally.
- Accept when blk_valid && blk_ready at edge E. Latch blk_is_luma and clear timeout_err at E.
- Timing is stated in cycles after E, where cycle k means the cycle after edge E+k-1.
- FSM states and encodings: IDLE=0, LOAD=1, DCT=2, DLATCH=3, QUANT=4, ZZ=5, HSTART=6, HWAIT=7, DONE=8.
- LOAD lasts 1 cycle with input_enable=1.
- DCT lasts DCT_CYCLES cycles with dct_enable=1.
- DLATCH lasts 1 cycle with dct_end_enable=1.
- QUANT:
  - For each row r=0..7, matrix_row=r is held for QUANT_LAT+1 cycles.
  - zigzag_input_enable=1 only on the last cycle of each row.
  - Total QUANT duration is 8*(QUANT_LAT+1) cycles.
  - matrix_row returns to 0 on exit from QUANT.
- ZZ lasts 1 cycle with zigag_enable=1.
- HSTART lasts 1 cycle with Huffman_start=1. huff_done is not sampled in this state.
- HWAIT:
  - A wait counter starts at 0 and increments each cycle.
  - If huff_done=1, go to DONE.
  - Otherwise, when the counter reaches HUFF_TIMEOUT-1, set timeout_err and go to DONE.
  - If huff_done and timeout occur in the same cycle, done wins and timeout_err stays 0.
- DONE lasts 1 cycle with block_done=1; block_count increments (all-ones wraps to 0). Next state is IDLE.
- blk_ready rises in the cycle after DONE, so back-to-back blocks have one IDLE cycle between them.
- blk_valid is ignored while busy. is_luminance stays stable from cycle 1 until the next accept.
- At most one strobe among input_enable, dct_end_enable, zigzag_input_enable, zigag_enable and Huffman_start is high in any cycle.
- Latency from accept to block_done (defaults, huff_done seen in the first HWAIT cycle) is 46 cycles.

Test Plan:
- Reset then idle: hold reset 3 cycles, release, blk_valid=0 for 10 cycles -> all outputs 0, blk_ready=1, state=0.
- Nominal luma block (defaults):
  - Stimulus: accept at E with blk_is_luma=1; huff_done pulsed in cycle 50.
  - input_enable in cycle 1; dct_enable in cycles 2..17; dct_end_enable in cycle 18.
  - matrix_row=r in cycles 19+3r..21+3r; zigzag_input_enable in cycles 21,24,..,42.
  - zigag_enable in cycle 43; Huffman_start in cycle 44; block_done in cycle 51; block_count=1; is_luminance=1 throughout.
- Busy rejection: assert blk_valid continuously from E with blk_is_luma toggling -> blk_ready=0 from cycle 1 through DONE; second accept exactly 1 cycle after block_done; is_luminance unchanged during the first block.
- Huffman timeout: HUFF_TIMEOUT=8, huff_done never asserted -> HWAIT lasts 8 cycles, timeout_err=1, block_done pulses, block_count increments. Next accept clears timeout_err.
- Early/simultaneous done: huff_done high during HSTART -> ignored there, sampled in the first HWAIT cycle, DONE follows. With HUFF_TIMEOUT=1 and huff_done high -> timeout_err stays 0.
- Reset mid-QUANT and wrap: assert reset at matrix_row=4 -> next cycle state=0, all outputs 0, no block_done. Separately, CNT_W=2 with 5 blocks -> block_count sequence 1,2,3,0,1.
